// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit seven-segment display multiplexer.
// Segment codes are active-low, bit 0 = a ... bit 6 = g.
package display_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } mux_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/display_mux_ctrl_seg_decoder.sv
// Combinational hex to active-low seven-segment decoder; zero latency, no flow control.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[hex];

endmodule

// File: rtl/display_mux_ctrl.sv
// Two-digit display time-multiplexer; all outputs registered, change on the state edge; no backpressure.
// DISPLAY_BLANK_EN adds all-off BLANK0/BLANK1 slots between digits; undefined gives a direct SHOW0<->SHOW1 swap.
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

`ifdef DISPLAY_BLANK_EN
  localparam int         MAX_N       = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam mux_state_t RESET_STATE = BLANK1;
`else
  localparam int         MAX_N       = DWELL_CYCLES;
  localparam mux_state_t RESET_STATE = SHOW1;
`endif
  localparam int CW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  mux_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_val;
  logic          last;
  logic [3:0]    dig0_q, dig0_d, dig1_q, dig1_d;
  logic [3:0]    dec_in;
  logic [6:0]    dec_out;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;

  always_comb begin
    last_val = BLANK_LAST;
    if (state_q == SHOW0 || state_q == SHOW1) last_val = DWELL_LAST;
    last    = (cnt_q == last_val);
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    if (last) begin
`ifdef DISPLAY_BLANK_EN
      case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        default: state_d = SHOW0;
      endcase
`else
      state_d = (state_q == SHOW0) ? SHOW1 : SHOW0;
`endif
    end
    // Digits are sampled only on the edge that enters their slot.
    dig0_d = dig0_q;
    dig1_d = dig1_q;
    if (last && state_d == SHOW0) dig0_d = s0;
    if (last && state_d == SHOW1) dig1_d = s1;
  end

  assign dec_in = (state_d == SHOW1) ? dig1_d : dig0_d;

  seg_decoder u_dec (
    .hex   (dec_in),
    .seg_n (dec_out)
  );

  // Outputs only move on a state change, so the post-reset slot stays dark until SHOW0.
  always_comb begin
    an_d         = an_q;
    seg_d        = seg_q;
    frame_done_d = 1'b0;
    if (last) begin
      case (state_d)
        SHOW0: begin
          an_d         = 2'b10;
          seg_d        = dec_out;
          frame_done_d = 1'b1;
        end
        SHOW1: begin
          an_d  = 2'b01;
          seg_d = dec_out;
        end
        default: begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q      <= RESET_STATE;
      cnt_q        <= '0;
      dig0_q       <= 4'h0;
      dig1_q       <= 4'h0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig0_q       <= dig0_d;
      dig1_q       <= dig1_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl with DWELL_CYCLES=4, BLANK_CYCLES=2; adapts to DISPLAY_BLANK_EN.
module tb_display_mux_ctrl;

`ifdef DISPLAY_BLANK_EN
  localparam int GAP       = 2;
  localparam int FIRST_OFF = 2;
`else
  localparam int GAP       = 0;
  localparam int FIRST_OFF = 4;
`endif
  localparam int PERIOD = 8 + 2 * GAP;

  localparam logic [6:0] EXP_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       int_osc = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] s0 = 4'h0;
  logic [3:0] s1 = 4'h0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  display_mux_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .int_osc    (int_osc),
    .reset      (reset),
    .s0         (s0),
    .s1         (s1),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 int_osc = ~int_osc;

  function automatic int phase(input int kk);
    return (kk < FIRST_OFF) ? -1 : (kk - FIRST_OFF) % PERIOD;
  endfunction

  function automatic logic [1:0] exp_an(input int ph);
    if (ph < 0)           return 2'b11;
    if (ph < 4)           return 2'b10;
    if (ph < 4 + GAP)     return 2'b11;
    if (ph < 8 + GAP)     return 2'b01;
    return 2'b11;
  endfunction

  task automatic tick();
    @(posedge int_osc);
    @(negedge int_osc);
    k++;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    s0 = 4'h1;
    s1 = 4'h8;
    @(negedge int_osc);
    checks++;
    if (an !== 2'b11) begin errors++; $display("FAIL reset_an got %b want 11", an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    @(negedge int_osc);
    reset = 1'b1;
    k = 0;
  endtask

  // Checks from the release sample through one full frame with s0=1, s1=8.
  task automatic test_first_frame();
    logic [1:0] ea;
    logic [6:0] es;
    for (int i = 0; i < FIRST_OFF + PERIOD; i++) begin
      if (i > 0) tick();
      ea = exp_an(phase(k));
      es = (ea == 2'b10) ? 7'h79 : (ea == 2'b01) ? 7'h00 : 7'h7F;
      checks++;
      if (an !== ea) begin errors++; $display("FAIL first_an k=%0d got %b want %b", k, an, ea); end
      checks++;
      if (seg !== es) begin errors++; $display("FAIL first_seg k=%0d got %h want %h", k, seg, es); end
      checks++;
      if (frame_done !== (phase(k) == 0)) begin
        errors++; $display("FAIL first_fd k=%0d got %b want %b", k, frame_done, phase(k) == 0);
      end
    end
  endtask

  task automatic test_midslot_change();
    logic [6:0] es;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      if (phase(k) < 4) begin
        es = (i < PERIOD) ? 7'h79 : 7'h0E;
        checks++;
        if (seg !== es) begin errors++; $display("FAIL midslot_seg k=%0d got %h want %h", k, seg, es); end
        if (i == 1) s0 = 4'hF;
      end
    end
  endtask

  task automatic test_frames();
    int last_fd = -1;
    int n_fd = 0;
    for (int i = 0; i < 5 * PERIOD; i++) begin
      tick();
      checks++;
      if (an === 2'b00) begin errors++; $display("FAIL frames_two_anodes k=%0d got %b", k, an); end
      if (an === 2'b11) begin
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL frames_blank_seg k=%0d got %h want 7f", k, seg); end
      end
      checks++;
      if (an !== exp_an(phase(k))) begin
        errors++; $display("FAIL frames_an k=%0d got %b want %b", k, an, exp_an(phase(k)));
      end
      if (frame_done === 1'b1) begin
        n_fd++;
        if (last_fd >= 0) begin
          checks++;
          if (k - last_fd != PERIOD) begin
            errors++; $display("FAIL frames_spacing got %0d want %0d", k - last_fd, PERIOD);
          end
        end
        last_fd = k;
      end
    end
    checks++;
    if (n_fd != 5) begin errors++; $display("FAIL frames_count got %0d want 5", n_fd); end
  endtask

  // s0 is changed on the cycle before SHOW0 entry, so the entry edge latches the new value.
  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      s0 = 4'(v);
      tick();
      checks++;
      if (an !== 2'b10) begin errors++; $display("FAIL sweep_an v=%0d got %b want 10", v, an); end
      checks++;
      if (seg !== EXP_SEG[v]) begin errors++; $display("FAIL sweep_seg v=%0d got %h want %h", v, seg, EXP_SEG[v]); end
      for (int j = 1; j < PERIOD; j++) tick();
    end
  endtask

  task automatic test_async_reset();
    while (phase(k) != 4 + GAP + 1) tick();
    checks++;
    if (an !== 2'b01) begin errors++; $display("FAIL async_pre_an got %b want 01", an); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (an !== 2'b11) begin errors++; $display("FAIL async_an got %b want 11", an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg got %h want 7f", seg); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL async_fd got %b want 0", frame_done); end
    s0 = 4'h1;
    s1 = 4'h8;
    @(negedge int_osc);
    @(negedge int_osc);
    reset = 1'b1;
    k = 0;
    test_first_frame();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_midslot_change();
    test_frames();
    test_sweep();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
